// File: rtl/keylock_pkg.sv
// rtl/keylock_pkg.sv - shared key codes, FSM state encoding and timer width for the keypad lock
//   Key codes: 0-9 digits, KEY_CLEAR, KEY_ENTER, KEY_SET; 13-15 carry no meaning.
//   state_t: sequencer states used by keylock_ctrl.
package keylock_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam logic [3:0] KEY_SET   = 4'd12;

    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_FAIL     = 3'd4,
        S_LOCKOUT  = 3'd5,
        S_SET      = 3'd6
    } state_t;

    function automatic logic is_digit_key(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/digit_accum.sv
// rtl/digit_accum.sv - decimal entry accumulator (value*10 + digit) with saturating digit count
//   hwclk, reset : clock, async active-high reset
//   clr          : zero the entry; together with digit_en the digit becomes the first of a new entry
//   digit_en     : accept digit
//   digit        : digit value 0-9
//   value, count : accumulated entry and number of digits accepted
module digit_accum #(
    parameter int NUM_DIGITS = 4
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        clr,
    input  logic        digit_en,
    input  logic [3:0]  digit,
    output logic [31:0] value,
    output logic [3:0]  count
);

    localparam logic [3:0] MAX_COUNT = 4'(NUM_DIGITS);

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            value <= 32'd0;
            count <= 4'd0;
        end else if (clr && digit_en) begin
            value <= {28'd0, digit};
            count <= 4'd1;
        end else if (clr) begin
            value <= 32'd0;
            count <= 4'd0;
        end else if (digit_en && (count < MAX_COUNT)) begin
            // Digits beyond the code length are dropped; count saturates.
            value <= value * 32'd10 + {28'd0, digit};
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/keylock_ctrl.sv
// rtl/keylock_ctrl.sv - keypad lock sequencer: entry, code check, unlock window, fail lockout, code change
//   hwclk, reset          : 12 MHz clock, async active-high reset
//   key_valid, key_code   : decoded key strobe and code
//   key_ready             : key presses are accepted this cycle
//   typed, digit_count    : current entry value and digit count
//   unlocked, fail_pulse  : lock open; one-cycle pulse per wrong entry
//   lockout, set_mode     : lockout active; new code being entered
//   fail_count            : consecutive wrong entries
module keylock_ctrl
    import keylock_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 24000000,
    parameter int UNLOCK_CYCLES  = 36000000,
    parameter int DEFAULT_CODE   = 1234
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [31:0] typed,
    output logic [3:0]  digit_count,
    output logic        unlocked,
    output logic        fail_pulse,
    output logic        lockout,
    output logic        set_mode,
    output logic [3:0]  fail_count
);

    localparam logic [3:0]         FULL_COUNT   = 4'(NUM_DIGITS);
    localparam logic [3:0]         FAIL_LIMIT   = 4'(MAX_FAILS);
    // Timers run down to zero inclusive, so load N-1 for an N-cycle window.
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [31:0]        code;

    logic key_acc;
    logic key_digit;
    logic key_enter;
    logic key_clear;
    logic key_set;
    logic acc_clr;
    logic acc_en;
    logic match;

    assign key_acc   = key_valid && key_ready;
    assign key_digit = key_acc && is_digit_key(key_code);
    assign key_enter = key_acc && (key_code == KEY_ENTER);
    assign key_clear = key_acc && (key_code == KEY_CLEAR);
    assign key_set   = key_acc && (key_code == KEY_SET);
    assign match     = (digit_count == FULL_COUNT) && (typed == code);

    always_comb begin
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state)
            S_IDLE: begin
                // First digit of a fresh entry replaces whatever was left behind.
                acc_clr = key_digit;
                acc_en  = key_digit;
            end
            S_ENTRY, S_SET: begin
                acc_en  = key_digit;
                acc_clr = key_clear;
            end
            S_CHECK:    acc_clr = 1'b1;
            S_UNLOCKED: acc_clr = key_set;
            default: begin
                acc_clr = 1'b0;
                acc_en  = 1'b0;
            end
        endcase
    end

    digit_accum #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_accum (
        .hwclk    (hwclk),
        .reset    (reset),
        .clr      (acc_clr),
        .digit_en (acc_en),
        .digit    (key_code),
        .value    (typed),
        .count    (digit_count)
    );

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            code       <= 32'(DEFAULT_CODE);
            fail_count <= 4'd0;
            unlocked   <= 1'b0;
            fail_pulse <= 1'b0;
            lockout    <= 1'b0;
            set_mode   <= 1'b0;
            key_ready  <= 1'b1;
        end else begin
            fail_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_digit) begin
                        state <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (key_enter) begin
                        state     <= S_CHECK;
                        key_ready <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        state      <= S_UNLOCKED;
                        fail_count <= 4'd0;
                        timer      <= UNLOCK_LOAD;
                        unlocked   <= 1'b1;
                        key_ready  <= 1'b1;
                    end else begin
                        state      <= S_FAIL;
                        fail_pulse <= 1'b1;
                        if (fail_count < FAIL_LIMIT) begin
                            fail_count <= fail_count + 4'd1;
                        end
                    end
                end
                S_FAIL: begin
                    if (fail_count == FAIL_LIMIT) begin
                        state   <= S_LOCKOUT;
                        timer   <= LOCKOUT_LOAD;
                        lockout <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        key_ready <= 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= S_IDLE;
                        lockout    <= 1'b0;
                        fail_count <= 4'd0;
                        key_ready  <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_UNLOCKED: begin
                    if ((timer == '0) || key_enter) begin
                        state    <= S_IDLE;
                        unlocked <= 1'b0;
                        timer    <= '0;
                    end else if (key_set) begin
                        state    <= S_SET;
                        unlocked <= 1'b0;
                        set_mode <= 1'b1;
                        timer    <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_SET: begin
                    if (key_enter) begin
                        // A short entry aborts the change and keeps the old code.
                        if (digit_count == FULL_COUNT) begin
                            code <= typed;
                        end
                        state    <= S_IDLE;
                        set_mode <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    unlocked   <= 1'b0;
                    lockout    <= 1'b0;
                    set_mode   <= 1'b0;
                    key_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keylock_ctrl.sv
// tb/tb_keylock_ctrl.sv - directed self-checking bench for keylock_ctrl
module tb_keylock_ctrl;

    logic        hwclk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        key_ready;
    logic [31:0] typed;
    logic [3:0]  digit_count;
    logic        unlocked;
    logic        fail_pulse;
    logic        lockout;
    logic        set_mode;
    logic [3:0]  fail_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] K_CLR = 4'd10;
    localparam logic [3:0] K_ENT = 4'd11;
    localparam logic [3:0] K_SET = 4'd12;

    keylock_ctrl #(
        .NUM_DIGITS     (4),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (20),
        .UNLOCK_CYCLES  (30),
        .DEFAULT_CODE   (1234)
    ) dut (
        .hwclk       (hwclk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .typed       (typed),
        .digit_count (digit_count),
        .unlocked    (unlocked),
        .fail_pulse  (fail_pulse),
        .lockout     (lockout),
        .set_mode    (set_mode),
        .fail_count  (fail_count)
    );

    always #5 hwclk = ~hwclk;

    // Key held across exactly one rising edge; returns at the following falling edge.
    task automatic press(input logic [3:0] k);
        @(negedge hwclk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge hwclk);
        key_valid = 1'b0;
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
        press(4'(d0));
        press(4'(d1));
        press(4'(d2));
        press(4'(d3));
        press(K_ENT);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge hwclk);
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
        n_checks++; if (typed !== 32'd0) begin n_fail++; $display("FAIL reset_typed: got %0d want 0", typed); end
        n_checks++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", digit_count); end
        n_checks++; if ({unlocked, fail_pulse, lockout, set_mode} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {unlocked, fail_pulse, lockout, set_mode}); end
        n_checks++; if (fail_count !== 4'd0) begin n_fail++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
        reset = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic test_correct_entry;
        int cnt;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        n_checks++; if (typed !== 32'd1234) begin n_fail++; $display("FAIL entry_typed: got %0d want 1234", typed); end
        n_checks++; if (digit_count !== 4'd4) begin n_fail++; $display("FAIL entry_count: got %0d want 4", digit_count); end
        press(K_ENT);
        n_checks++; if ({unlocked, key_ready} !== 2'b00) begin n_fail++; $display("FAIL check_cycle: unlocked,key_ready got %b want 00", {unlocked, key_ready}); end
        @(negedge hwclk);
        n_checks++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL unlock_latency: got %b want 1", unlocked); end
        n_checks++; if (typed !== 32'd0) begin n_fail++; $display("FAIL typed_cleared: got %0d want 0", typed); end
        cnt = 0;
        while (unlocked === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge hwclk);
        end
        n_checks++; if (cnt !== 30) begin n_fail++; $display("FAIL unlock_window: got %0d cycles want 30", cnt); end
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL relock_ready: got %b want 1", key_ready); end
    endtask

    task automatic test_wrong_entry;
        enter_code(1, 2, 3, 5);
        @(negedge hwclk);
        n_checks++; if (fail_pulse !== 1'b1) begin n_fail++; $display("FAIL wrong_pulse: got %b want 1", fail_pulse); end
        n_checks++; if (fail_count !== 4'd1) begin n_fail++; $display("FAIL wrong_count1: got %0d want 1", fail_count); end
        n_checks++; if (unlocked !== 1'b0) begin n_fail++; $display("FAIL wrong_unlocked: got %b want 0", unlocked); end
        @(negedge hwclk);
        n_checks++; if (fail_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b want 0", fail_pulse); end
        press(4'd1); press(4'd2); press(4'd3); press(K_ENT);
        @(negedge hwclk);
        n_checks++; if (fail_count !== 4'd2) begin n_fail++; $display("FAIL short_count2: got %0d want 2", fail_count); end
        @(negedge hwclk);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        n_checks++; if (typed !== 32'd1234) begin n_fail++; $display("FAIL sat_typed: got %0d want 1234", typed); end
        n_checks++; if (digit_count !== 4'd4) begin n_fail++; $display("FAIL sat_count: got %0d want 4", digit_count); end
        press(K_ENT);
        @(negedge hwclk);
        n_checks++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL sat_unlock: got %b want 1", unlocked); end
        n_checks++; if (fail_count !== 4'd0) begin n_fail++; $display("FAIL fail_clear: got %0d want 0", fail_count); end
        press(K_ENT);
        n_checks++; if (unlocked !== 1'b0) begin n_fail++; $display("FAIL enter_relock: got %b want 0", unlocked); end
    endtask

    task automatic three_fails;
        for (int i = 0; i < 3; i++) begin
            enter_code(9, 9, 9, 9);
            @(negedge hwclk);
            n_checks++; if (fail_count !== 4'(i + 1)) begin n_fail++; $display("FAIL lock_count%0d: got %0d want %0d", i, fail_count, i + 1); end
            @(negedge hwclk);
        end
    endtask

    task automatic test_lockout;
        int cnt;
        three_fails();
        n_checks++; if ({lockout, key_ready} !== 2'b10) begin n_fail++; $display("FAIL lockout_entry: lockout,key_ready got %b want 10", {lockout, key_ready}); end
        cnt = 0;
        while (lockout === 1'b1 && cnt < 100) begin
            cnt++;
            key_valid = (cnt == 5);
            key_code  = 4'd1;
            @(negedge hwclk);
        end
        key_valid = 1'b0;
        n_checks++; if (cnt !== 20) begin n_fail++; $display("FAIL lockout_len: got %0d cycles want 20", cnt); end
        n_checks++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL lockout_key_dropped: count got %0d want 0", digit_count); end
        n_checks++; if (fail_count !== 4'd0) begin n_fail++; $display("FAIL lockout_fail_clear: got %0d want 0", fail_count); end
        enter_code(1, 2, 3, 4);
        @(negedge hwclk);
        n_checks++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL post_lockout_unlock: got %b want 1", unlocked); end
        press(K_ENT);
    endtask

    task automatic test_code_change;
        enter_code(1, 2, 3, 4);
        @(negedge hwclk);
        press(K_SET);
        n_checks++; if ({set_mode, unlocked} !== 2'b10) begin n_fail++; $display("FAIL set_entry: set_mode,unlocked got %b want 10", {set_mode, unlocked}); end
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        n_checks++; if (typed !== 32'd9876) begin n_fail++; $display("FAIL set_typed: got %0d want 9876", typed); end
        press(K_ENT);
        n_checks++; if ({set_mode, key_ready} !== 2'b01) begin n_fail++; $display("FAIL set_exit: set_mode,key_ready got %b want 01", {set_mode, key_ready}); end
        enter_code(1, 2, 3, 4);
        @(negedge hwclk);
        n_checks++; if ({fail_pulse, unlocked} !== 2'b10) begin n_fail++; $display("FAIL old_code_rejected: pulse,unlocked got %b want 10", {fail_pulse, unlocked}); end
        @(negedge hwclk);
        enter_code(9, 8, 7, 6);
        @(negedge hwclk);
        n_checks++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL new_code_unlock: got %b want 1", unlocked); end
        press(K_SET); press(4'd5); press(K_ENT);
        enter_code(9, 8, 7, 6);
        @(negedge hwclk);
        n_checks++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL short_set_kept: got %b want 1", unlocked); end
        press(K_ENT);
    endtask

    task automatic test_clear;
        press(4'd7); press(4'd7); press(K_CLR);
        n_checks++; if ({typed, digit_count} !== 36'd0) begin n_fail++; $display("FAIL clear_entry: typed %0d count %0d want 0 0", typed, digit_count); end
        enter_code(9, 8, 7, 6);
        @(negedge hwclk);
        n_checks++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL clear_unlock: got %b want 1", unlocked); end
        press(K_ENT);
        n_checks++; if (unlocked !== 1'b0) begin n_fail++; $display("FAIL clear_relock: got %b want 0", unlocked); end
    endtask

    task automatic test_async_reset;
        three_fails();
        repeat (3) @(negedge hwclk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({lockout, key_ready, fail_count} !== 6'b010000) begin n_fail++; $display("FAIL areset_lockout: lockout,ready,fails got %b want 010000", {lockout, key_ready, fail_count}); end
        @(negedge hwclk);
        reset = 1'b0;
        enter_code(1, 2, 3, 4);
        @(negedge hwclk);
        n_checks++; if (unlocked !== 1'b1) begin n_fail++; $display("FAIL areset_code_default: got %b want 1", unlocked); end
        press(K_SET); press(4'd4); press(4'd4);
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({set_mode, unlocked, key_ready, typed} !== {3'b001, 32'd0}) begin n_fail++; $display("FAIL areset_set: set,unl,ready %b typed %0d want 001 0", {set_mode, unlocked, key_ready}, typed); end
        @(negedge hwclk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_correct_entry();
        test_wrong_entry();
        test_lockout();
        test_code_change();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
